// File: rtl/inbyte115200_1_8_if.sv
// rtl/inbyte115200_1_8_if.sv - Bream call/return handshake bundle for inbyte115200_1_8
interface inbyte115200_1_8_if;
  logic       start;
  logic [7:0] result;
  logic       result_ready;

  modport master (output start, input result, input result_ready);
  modport slave  (input start, output result, output result_ready);
endinterface

// File: rtl/inbyte115200_1_8.sv
// rtl/inbyte115200_1_8.sv - 8N1 serial byte receiver with FIFO behind a Bream call port
// Optional stop-bit checking: INBYTE_FRAMING_CHECK_EN
module inbyte115200_1_8 #(
  parameter int CLK_HZ     = 100000000,
  parameter int BAUD       = 115200,
  parameter int OVS_DIV    = CLK_HZ / (BAUD * 16),
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  inbyte115200_1_8_if.slave  bream,
  input  logic               inchan,
  output logic               overrun,
  output logic               framing_error
);
  localparam int          PW          = $clog2(FIFO_DEPTH);
  localparam logic [11:0] TICK_RELOAD = 12'(OVS_DIV - 1);
  localparam logic [PW:0] FULL_CNT    = (PW + 1)'(FIFO_DEPTH);
  localparam logic [PW:0] CNT_ONE     = (PW + 1)'(1);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;
  typedef enum logic [1:0] {ST_READY = 2'b00, ST_WAITING = 2'b01, ST_NEVERNEVER = 2'b11} st_t;

  logic        sync1, rx;
  logic [11:0] div_cnt;
  logic        tick, mid;
  rx_state_t   rx_state, rx_next;
  logic [3:0]  os_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        push, pop, wr_en, empty, full;
  logic [7:0]  mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count;
  st_t         st, st_next;
  logic [7:0]  result_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rx    <= 1'b1;
    end else begin
      sync1 <= inchan;
      rx    <= sync1;
    end
  end

  assign tick = (div_cnt == 12'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    div_cnt <= TICK_RELOAD;
    else if (tick) div_cnt <= TICK_RELOAD;
    else           div_cnt <= div_cnt - 12'd1;
  end

  // os_cnt wraps 15->0, so mid-bit lands every 16 ticks once in DATA/STOP
  assign mid = tick && (os_cnt == 4'd15);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_state <= RX_IDLE;
    else        rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (tick && !rx) rx_next = RX_START;
      RX_START: if (tick && os_cnt == 4'd7) rx_next = rx ? RX_IDLE : RX_DATA;
      RX_DATA:  if (mid && bit_idx == 3'd7) rx_next = RX_STOP;
      RX_STOP: begin
        if (mid) begin
`ifdef INBYTE_FRAMING_CHECK_EN
          rx_next = rx ? RX_IDLE : RX_BREAK;
`else
          rx_next = RX_IDLE;
`endif
        end
      end
      RX_BREAK: if (tick && rx) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

`ifdef INBYTE_FRAMING_CHECK_EN
  logic frame_bad;
  always_comb begin
    push      = 1'b0;
    frame_bad = 1'b0;
    if (rx_state == RX_STOP && mid) begin
      push      = rx;
      frame_bad = !rx;
    end
  end
`else
  always_comb begin
    push = 1'b0;
    if (rx_state == RX_STOP && mid) push = 1'b1;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      os_cnt  <= 4'd0;
      bit_idx <= 3'd0;
      shreg   <= 8'd0;
    end else if (tick) begin
      case (rx_state)
        RX_START: begin
          if (os_cnt == 4'd7) begin
            os_cnt  <= 4'd0;
            bit_idx <= 3'd0;
          end else begin
            os_cnt <= os_cnt + 4'd1;
          end
        end
        RX_DATA: begin
          os_cnt <= os_cnt + 4'd1;
          if (os_cnt == 4'd15) begin
            shreg   <= {rx, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
          end
        end
        RX_STOP: os_cnt <= os_cnt + 4'd1;
        default: os_cnt <= 4'd0;
      endcase
    end
  end

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_en, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              overrun <= 1'b0;
    else if (push && !wr_en) overrun <= 1'b1;
  end

`ifdef INBYTE_FRAMING_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         framing_error <= 1'b0;
    else if (frame_bad) framing_error <= 1'b1;
  end
`else
  assign framing_error = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= ST_READY;
    else        st <= st_next;
  end

  // a new call always restarts the wait; the pop itself is gated only by state
  always_comb begin
    st_next = st;
    if (bream.start) begin
      st_next = ST_WAITING;
    end else begin
      case (st)
        ST_READY:   st_next = ST_READY;
        ST_WAITING: if (!empty) st_next = ST_READY;
        default:    st_next = ST_READY;
      endcase
    end
  end

  always_comb begin
    pop                = (st == ST_WAITING) && !empty;
    bream.result_ready = (st == ST_READY) && !bream.start;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   result_q <= 8'd0;
    else if (pop) result_q <= mem[rd_ptr];
  end

  assign bream.result = result_q;
endmodule

// File: doc/inbyte115200_1_8.md
# inbyte115200_1_8

Bream-callable serial byte receiver: the receive-side counterpart of `outbyte115200_1_1_8`. It deserialises 8N1 frames arriving on `inchan` at 115200 bps from a 100 MHz clock and buffers completed bytes in a small FIFO. Each Bream call (`start` pulse) returns the oldest buffered byte on `result`, waiting for one to arrive if the FIFO is empty. It sits between an external RX pin and the Bream call/return handshake fabric.

## Interface
- `CLK_HZ`, 100000000, system clock frequency.
- `BAUD`, 115200, line rate.
- `OVS_DIV`, CLK_HZ/(BAUD*16) truncated (54), clocks per 16x oversample tick; counter width 12 bits.
- `FIFO_DEPTH`, 4, received-byte buffer depth; power of two, at least 2.
- `clk  input  1  system clock, rising edge.`
- `rst_n  input  1  reset, asynchronous, active-low.`
- `start  input  1  Bream call strobe: one-cycle pulse requesting one byte.`
- `inchan  input  1  serial RX line, idle high, asynchronous to clk.`
- `result  output  8  returned byte; held stable until the next completed call.`
- `result_ready  output  1  (state==ST_READY) & ~start.`
- `overrun  output  1  sticky: a completed frame was dropped because the FIFO was full.`
- `framing_error  output  1  sticky: a frame with stop bit 0 was seen (tied 0 without the config macro).`

## Operation
- Input conditioning: two-flop synchroniser on `inchan`, reset value 1; all logic uses the synchronised value.
- Tick generator: counter reloads to OVS_DIV-1 on reset or at 0; a one-cycle `tick` pulse is generated at each 0.
- RX FSM, advancing on `tick`:
  - RX_IDLE: on synchronised line low, clear tick count, go to RX_START.
  - RX_START: at tick count 7, line still low -> RX_DATA with bit index 0; line high -> RX_IDLE (glitch rejected).
  - RX_DATA: sample every 16 ticks (mid-bit), shift in LSB first; after bit 7 -> RX_STOP.
  - RX_STOP: sample mid stop bit, then push the byte and return to RX_IDLE on the same tick, so a following start edge is accepted without waiting out the stop bit.
- FIFO: circular buffer with pointer width log2(FIFO_DEPTH) and a count of log2(FIFO_DEPTH)+1 bits. If the FIFO is full at push time, the new byte is discarded and `overrun` is set; the stored bytes are kept. A push and a pop in the same cycle are both honoured, and the count is unchanged.
- Call FSM:
  - ST_READY: `start` -> ST_WAITING.
  - ST_WAITING: FIFO non-empty -> pop, `result` <= head, -> ST_READY. Otherwise stay.
  - `start` in any state forces ST_WAITING and never causes a double pop.
  - ST_NEVERNEVER (encoding 2'b11) -> ST_READY.
- Sticky flags clear only on reset.

## Timing
- Reset values: `result`=0, call state ST_READY (so `result_ready`=~`start`), `overrun`=0, `framing_error`=0, FIFO empty, RX_IDLE, tick counter OVS_DIV-1.
- Bit period is 16*OVS_DIV = 864 clocks (115741 bps actual, +0.47%).
- Synchroniser latency is 2 cycles. A byte is pushed on the tick at mid stop bit, about 9.5 bit periods after the start edge.
- Call latency, FIFO non-empty: `start` high at edge N; pop at edge N+1; `result` valid and `result_ready` high after edge N+1.
- Call latency, FIFO empty: pop happens on the cycle after the push edge; `result_ready` rises 1 cycle after the byte is pushed.
- Asynchronous reset mid-frame or mid-call aborts the frame or call, empties the FIFO, and returns all outputs to their reset values.

## Configuration
- `INBYTE_FRAMING_CHECK_EN` defined:
  - A frame whose sampled stop bit is 0 is discarded, not pushed.
  - `framing_error` is set.
  - RX returns to RX_IDLE only after the line has been seen high on a tick, so a break condition is not re-read as repeated frames.
- Undefined:
  - The stop bit is ignored and every frame is pushed.
  - `framing_error` is constant 0.

## Test plan
- Reset, then send 0xA5 (864 clk/bit), then pulse `start` -> `result`=0xA5, `result_ready` high exactly 2 cycles after the `start` edge.
- Pulse `start` with the FIFO empty, then send 0x3C 5000 cycles later -> `result_ready` low throughout, then high 1 cycle after the push with `result`=0x3C.
- Send 5 bytes 0x01..0x05 back-to-back without calls, then make 5 calls -> the first 4 return 0x01..0x04, `overrun`=1, and the fifth call waits.
- Drive a 300-clock low glitch on `inchan` -> no push, FIFO count stays 0, RX back in RX_IDLE.
- Send 0x55 with stop bit forced to 0 -> with the macro: not pushed and `framing_error`=1; without it: pushed and `framing_error`=0.
- Assert `rst_n` low at mid data bit 4 of a frame -> all outputs return to reset values immediately; the next full frame 0x96 is received correctly.
